// File: rtl/control_input_debouncer.sv
// Switch/pushbutton conditioner: per-input metastability synchronizer, stable-count
// debounce, and registered one-cycle press/release pulses on accepted transitions.

module control_input_debouncer_lane #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel
);
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync <= '0;
    else          sync <= {sync[SYNC_STAGES-2:0], raw};
  end

  // Any return to the current level restarts the count; only a full run is accepted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else if (s == level) begin
      cnt   <= '0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      level <= s;
      press <= s;
      rel   <= ~s;
    end else begin
      cnt   <= cnt + 1'b1;
      press <= 1'b0;
      rel   <= 1'b0;
    end
  end
endmodule

module control_input_debouncer #(
  parameter int NUM_INPUTS      = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_INPUTS-1:0] raw_in,
  output logic [NUM_INPUTS-1:0] level_out,
  output logic [NUM_INPUTS-1:0] press_pulse,
  output logic [NUM_INPUTS-1:0] release_pulse
);
  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_lane
    control_input_debouncer_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_lane (
      .clock  (clock),
      .reset_n(reset_n),
      .raw    (raw_in[g]),
      .level  (level_out[g]),
      .press  (press_pulse[g]),
      .rel    (release_pulse[g])
    );
  end
endmodule

// File: tb/tb_control_input_debouncer.sv
// Cycle-vector bench for control_input_debouncer (DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
// hand-derived expected outputs per edge, queued on drive and compared after the edge.

module tb_control_input_debouncer;
  localparam int N = 5;

  logic         clock = 1'b0;
  logic         reset_n = 1'b1;
  logic [N-1:0] raw_in = '0;
  logic [N-1:0] level_out, press_pulse, release_pulse;

  control_input_debouncer #(
    .NUM_INPUTS(N), .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .raw_in       (raw_in),
    .level_out    (level_out),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic         rst_n;
    logic [N-1:0] raw;
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rls;
  } vec_t;

  typedef struct {
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rls;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_no = 0;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s edge=%0d got=%b want=%b", name, edge_no, act, req);
    end
  endtask

  task automatic add(input int n, input logic r, input logic [N-1:0] raw,
                     input logic [N-1:0] l, input logic [N-1:0] p, input logic [N-1:0] q);
    for (int i = 0; i < n; i++) vecs.push_back('{r, raw, l, p, q});
  endtask

  // Drive before an edge, queue what the outputs must be after it, then compare.
  task automatic step(input logic r, input logic [N-1:0] raw,
                      input logic [N-1:0] l, input logic [N-1:0] p, input logic [N-1:0] q);
    exp_t e;
    @(negedge clock);
    reset_n = r;
    raw_in  = raw;
    sb.push_back('{l, p, q});
    @(posedge clock);
    #1;
    edge_no++;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty edge=%0d got=0 want=1", edge_no);
    end else begin
      e = sb.pop_front();
      chk("level", level_out, e.lvl);
      chk("press", press_pulse, e.prs);
      chk("release", release_pulse, e.rls);
    end
  endtask

  initial begin
    #1 reset_n = 1'b0;
    raw_in = 5'b11111;

    // reset held with all inputs high, then release
    add(3, 0, 5'h1F, 5'h00, 5'h00, 5'h00);
    add(5, 1, 5'h1F, 5'h00, 5'h00, 5'h00);
    add(1, 1, 5'h1F, 5'h1F, 5'h1F, 5'h00);
    add(1, 1, 5'h1F, 5'h1F, 5'h00, 5'h00);
    // all released together
    add(5, 1, 5'h00, 5'h1F, 5'h00, 5'h00);
    add(1, 1, 5'h00, 5'h00, 5'h00, 5'h1F);
    add(1, 1, 5'h00, 5'h00, 5'h00, 5'h00);
    // clean press / release on bit 0
    add(5, 1, 5'h01, 5'h00, 5'h00, 5'h00);
    add(1, 1, 5'h01, 5'h01, 5'h01, 5'h00);
    add(1, 1, 5'h01, 5'h01, 5'h00, 5'h00);
    add(5, 1, 5'h00, 5'h01, 5'h00, 5'h00);
    add(1, 1, 5'h00, 5'h00, 5'h00, 5'h01);
    add(1, 1, 5'h00, 5'h00, 5'h00, 5'h00);
    // bit 2: 3-cycle glitch rejected
    add(3, 1, 5'h04, 5'h00, 5'h00, 5'h00);
    add(7, 1, 5'h00, 5'h00, 5'h00, 5'h00);
    // bit 2: exactly 4 cycles accepted, then released
    add(4, 1, 5'h04, 5'h00, 5'h00, 5'h00);
    add(1, 1, 5'h00, 5'h00, 5'h00, 5'h00);
    add(1, 1, 5'h00, 5'h04, 5'h04, 5'h00);
    add(3, 1, 5'h00, 5'h04, 5'h00, 5'h00);
    add(1, 1, 5'h00, 5'h00, 5'h00, 5'h04);
    add(1, 1, 5'h00, 5'h00, 5'h00, 5'h00);
    // bit 1 bounce 1,0,1,0,1 then hold
    add(1, 1, 5'h02, 5'h00, 5'h00, 5'h00);
    add(1, 1, 5'h00, 5'h00, 5'h00, 5'h00);
    add(1, 1, 5'h02, 5'h00, 5'h00, 5'h00);
    add(1, 1, 5'h00, 5'h00, 5'h00, 5'h00);
    add(5, 1, 5'h02, 5'h00, 5'h00, 5'h00);
    add(1, 1, 5'h02, 5'h02, 5'h02, 5'h00);
    add(1, 1, 5'h02, 5'h02, 5'h00, 5'h00);
    // bit 0 accepted high, then 3/4 rise while 0 falls
    add(5, 1, 5'h03, 5'h02, 5'h00, 5'h00);
    add(1, 1, 5'h03, 5'h03, 5'h01, 5'h00);
    add(1, 1, 5'h03, 5'h03, 5'h00, 5'h00);
    add(5, 1, 5'h1A, 5'h03, 5'h00, 5'h00);
    add(1, 1, 5'h1A, 5'h1A, 5'h18, 5'h01);
    add(1, 1, 5'h1A, 5'h1A, 5'h00, 5'h00);

    foreach (vecs[i]) step(vecs[i].rst_n, vecs[i].raw, vecs[i].lvl, vecs[i].prs, vecs[i].rls);

    // asynchronous clear while levels are high
    @(negedge clock);
    reset_n = 1'b0;
    raw_in  = 5'h00;
    #1;
    chk("async_clr_level", level_out, 5'h00);
    chk("async_clr_press", press_pulse, 5'h00);
    chk("async_clr_release", release_pulse, 5'h00);
    step(0, 5'h00, 5'h00, 5'h00, 5'h00);
    step(1, 5'h00, 5'h00, 5'h00, 5'h00);
    step(1, 5'h00, 5'h00, 5'h00, 5'h00);

    // reset mid-count: bit 0 rises, reset after 3 edges, count restarts from scratch
    for (int i = 0; i < 3; i++) step(1, 5'h01, 5'h00, 5'h00, 5'h00);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("midcnt_clr_level", level_out, 5'h00);
    chk("midcnt_clr_press", press_pulse, 5'h00);
    step(0, 5'h01, 5'h00, 5'h00, 5'h00);
    for (int i = 0; i < 5; i++) step(1, 5'h01, 5'h00, 5'h00, 5'h00);
    step(1, 5'h01, 5'h01, 5'h01, 5'h00);
    step(1, 5'h01, 5'h01, 5'h00, 5'h00);
    step(1, 5'h01, 5'h01, 5'h00, 5'h00);

    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/control_input_debouncer.md
Name: control_input_debouncer

Overview:
- Conditions raw board switches and pushbuttons (record/play track select, record, play) before they reach the display, record and playback logic.
- Each input is synchronized and debounced independently.
- Outputs per input: a clean level, a one-cycle press pulse and a one-cycle release pulse.
- Sits between the board pins and every consumer of user controls, including the seven-segment track display.

Parameters:
- NUM_INPUTS, 5: number of independent raw inputs handled.
- DEBOUNCE_CYCLES, 1000000: consecutive stable clock cycles required to accept a new level (10 ms at 100 MHz). Legal range is 2 or more.
- SYNC_STAGES, 2: flip-flop depth of the metastability synchronizer per input. Legal range is 2 or more.

Ports:
- clock  input  1  system clock (100 MHz).
- reset_n  input  1  asynchronous active-low reset.
- raw_in  input  NUM_INPUTS  asynchronous switch/button levels from pins.
- level_out  output  NUM_INPUTS  debounced level per input.
- press_pulse  output  NUM_INPUTS  one-cycle high when level_out[i] goes 0->1.
- release_pulse  output  NUM_INPUTS  one-cycle high when level_out[i] goes 1->0.

Behaviour:
- Interface: one clock (clock); reset_n is asynchronous, active-low. All state is cleared immediately on reset_n low; release is used synchronously.
- Reset values:
  - All synchronizer flops 0.
  - level_out = 0, press_pulse = 0, release_pulse = 0.
  - All counters 0.
- Per input i, fully independent, no cross-input interaction.
- Synchronizer: raw_in[i] passes through a SYNC_STAGES-deep flop chain. The last stage is s[i]. raw_in is never used combinationally.
- Counter: cnt[i], width $clog2(DEBOUNCE_CYCLES), never wraps.
- Per clock edge, in priority order:
  - If s[i] == level_out[i]: cnt[i] <= 0. Pulses are 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: level_out[i] <= s[i], cnt[i] <= 0. Assert press_pulse[i] if s[i] = 1, otherwise release_pulse[i], for exactly this one cycle.
  - Else: cnt[i] <= cnt[i]+1.
- Any return of s[i] to level_out[i] before acceptance restarts the count from 0. Glitches shorter than DEBOUNCE_CYCLES synchronized cycles never reach level_out.
- Latency: a clean raw_in change sampled at edge k is reflected on level_out at edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1. That is SYNC_STAGES+DEBOUNCE_CYCLES edges, counting edge k. The pulse is asserted on the same edge.
- Pulses are registered outputs. press_pulse[i] and release_pulse[i] are never high together. Each pulse is high for exactly one cycle per accepted transition.
- Simultaneous changes on several inputs are handled in parallel. Pulses may coincide across different bits.
- Input held high through reset release: level_out stays 0 until the debounce completes, then press_pulse fires once. Consumers treat this as a genuine press.
- Reset asserted mid-count: counter and level are cleared immediately. No pulse is emitted, then or on release.

Test Plan:
- All sequences below use DEBOUNCE_CYCLES=4, SYNC_STAGES=2, NUM_INPUTS=5.
- Reset: hold reset_n=0 with raw_in=5'b11111 -> level_out=0, pulses=0 throughout reset; after release, level_out=5'b11111 exactly 6 edges later, with press_pulse=5'b11111 for one cycle.
- Clean press/release on bit 0: raw_in[0] 0->1 before edge k -> level_out[0]=1 and press_pulse[0]=1 after edge k+5, press_pulse[0]=0 after k+6; raw_in[0] 1->0 -> release_pulse[0] one cycle, 6 edges later.
- Glitch rejection: raw_in[2] high for 3 cycles then low -> level_out[2] stays 0 and no pulses; high for exactly 4 cycles -> accepted, press_pulse[2] once; when it then goes low, release_pulse[2] fires once.
- Bounce: raw_in[1] toggles 1,0,1,0,1 at one-cycle spacing then holds 1 -> exactly one press_pulse[1], 6 edges after the final rising edge; never any release_pulse[1].
- Parallel inputs: raw_in[3] and raw_in[4] rise on the same edge while raw_in[0] falls from an accepted 1 -> press_pulse=5'b11000 and release_pulse=5'b00001 on the same cycle.
- Reset mid-count: raw_in[0] rises, reset_n pulses low after 3 edges -> outputs cleared immediately, no pulse; after release, acceptance occurs 6 edges later.
